// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
// Configuration controller for the HDMI/VGA timing generator.
// The host writes timing values into shadow registers. A commit validates the
// shadow set, waits for the next vertical-sync start (or a timeout), then
// copies the set into the live registers atomically. After that it holds the
// generator in reset for RST_CYCLES cycles, so a mode change never produces a
// torn frame.
//
// Ports:
//   clk          pixel clock, same clock as the generator
//   reset_n      asynchronous active-low reset
//   cfg_wr       shadow write strobe; cfg_addr selects the register, cfg_wdata is the value
//                (0..7 = h_total,h_sync,h_start,h_end,v_total,v_sync,v_start,v_end)
//   cfg_commit   request to validate and apply the shadow set
//   vga_vs       generator vsync, active-low
//   gen_reset_n  active-low reset to the generator
//   h_*/v_*      live timing values (12 bit)
//   v_active_*   derived quarter lines of the active area
//   cfg_busy     apply in progress
//   cfg_done     one-cycle pulse when an apply completes
//   cfg_err      one-cycle pulse when a commit is rejected
//   cfg_timeout  sticky; set when the last apply was forced by the vsync timeout
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned TIMEOUT_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  input  logic        cfg_commit,
  input  logic        vga_vs,
  output logic        gen_reset_n,
  output logic [11:0] h_total,
  output logic [11:0] h_sync,
  output logic [11:0] h_start,
  output logic [11:0] h_end,
  output logic [11:0] v_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_start,
  output logic [11:0] v_end,
  output logic [11:0] v_active_14,
  output logic [11:0] v_active_24,
  output logic [11:0] v_active_34,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        cfg_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);

  // Reset defaults for the register set (1080p60).
  function automatic logic [11:0] default_val(input logic [2:0] idx);
    logic [11:0] v;
    case (idx)
      3'd0:    v = 12'd2199;
      3'd1:    v = 12'd43;
      3'd2:    v = 12'd189;
      3'd3:    v = 12'd2109;
      3'd4:    v = 12'd1124;
      3'd5:    v = 12'd4;
      3'd6:    v = 12'd40;
      3'd7:    v = 12'd1120;
      default: v = 12'd0;
    endcase
    return v;
  endfunction

  // A set is usable only if sync < start < end <= total on both axes.
  // Each total must also be at least 2.
  function automatic logic set_valid(input logic [11:0] ht, input logic [11:0] hs,
                                     input logic [11:0] hst, input logic [11:0] he,
                                     input logic [11:0] vt, input logic [11:0] vs,
                                     input logic [11:0] vst, input logic [11:0] ve);
    return (hs < hst) && (hst < he) && (he <= ht) &&
           (vs < vst) && (vst < ve) && (ve <= vt) &&
           (ht >= 12'd2) && (vt >= 12'd2);
  endfunction

  state_t                r_state;
  state_t                w_nxt_state;
  logic [7:0]            r_hold_cnt;
  logic [7:0]            w_nxt_hold_cnt;
  logic [TIMEOUT_W-1:0]  r_to_cnt;
  logic [TIMEOUT_W-1:0]  w_nxt_to_cnt;
  logic                  r_vs_d;
  logic [11:0]           r_shadow [0:7];
  logic [11:0]           r_live   [0:7];
  logic [11:0]           r_q14;
  logic [11:0]           r_q24;
  logic [11:0]           r_q34;
  logic                  r_gen_reset_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_timeout;

  logic                  w_nxt_gen_reset_n;
  logic                  w_nxt_busy;
  logic                  w_nxt_done;
  logic                  w_nxt_err;
  logic                  w_nxt_timeout;
  logic                  w_load_live;
  logic                  w_sync_start;
  logic                  w_to_expired;
  logic                  w_valid;
  logic [11:0]           w_len;
  logic [11:0]           w_q14;
  logic [11:0]           w_q24;
  logic [11:0]           w_q34;

  assign w_sync_start = r_vs_d & ~vga_vs;
  assign w_to_expired = &r_to_cnt;
  assign w_valid      = set_valid(r_shadow[0], r_shadow[1], r_shadow[2], r_shadow[3],
                                  r_shadow[4], r_shadow[5], r_shadow[6], r_shadow[7]);

  // Quarter lines of the active vertical area, computed from the shadow set being applied.
  assign w_len = r_shadow[7] - r_shadow[6];
  assign w_q14 = r_shadow[6] + (w_len >> 2);
  assign w_q24 = r_shadow[6] + (w_len >> 1);
  assign w_q34 = r_shadow[6] + (w_len >> 1) + (w_len >> 2);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state and next-value logic for counters and status flags.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_hold_cnt    = r_hold_cnt;
    w_nxt_to_cnt      = r_to_cnt;
    w_nxt_gen_reset_n = r_gen_reset_n;
    w_nxt_busy        = r_busy;
    w_nxt_done        = 1'b0;
    w_nxt_err         = 1'b0;
    w_nxt_timeout     = r_timeout;
    w_load_live       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_commit) begin
          if (w_valid) begin
            w_nxt_state   = S_WAIT_VS;
            w_nxt_busy    = 1'b1;
            w_nxt_to_cnt  = '0;
            w_nxt_timeout = 1'b0;
          end else begin
            w_nxt_err = 1'b1;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_WAIT_VS: begin
        if (w_sync_start || w_to_expired) begin
          w_nxt_state       = S_HOLD;
          w_nxt_hold_cnt    = 8'd0;
          w_nxt_gen_reset_n = 1'b0;
          w_load_live       = 1'b1;
          // A real vsync edge takes priority over a simultaneous timeout.
          w_nxt_timeout     = ~w_sync_start;
        end else begin
          w_nxt_to_cnt = r_to_cnt + TIMEOUT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_nxt_state       = S_IDLE;
          w_nxt_hold_cnt    = 8'd0;
          w_nxt_gen_reset_n = 1'b1;
          w_nxt_busy        = 1'b0;
          w_nxt_done        = 1'b1;
        end else begin
          w_nxt_hold_cnt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_nxt_state       = S_HOLD;
        w_nxt_hold_cnt    = 8'd0;
        w_nxt_gen_reset_n = 1'b0;
        w_nxt_busy        = 1'b1;
      end
    endcase
  end

  // Counters, status flags and the vsync delay register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt    <= 8'd0;
      r_to_cnt      <= '0;
      r_vs_d        <= 1'b1;
      r_gen_reset_n <= 1'b0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_hold_cnt    <= w_nxt_hold_cnt;
      r_to_cnt      <= w_nxt_to_cnt;
      r_vs_d        <= vga_vs;
      r_gen_reset_n <= w_nxt_gen_reset_n;
      r_busy        <= w_nxt_busy;
      r_done        <= w_nxt_done;
      r_err         <= w_nxt_err;
      r_timeout     <= w_nxt_timeout;
    end
  end

  // Shadow registers. Host writes are accepted only while no apply is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= default_val(3'(i));
      end
    end else if (cfg_wr && !r_busy) begin
      r_shadow[cfg_addr] <= cfg_wdata;
    end else begin
      r_shadow[cfg_addr] <= r_shadow[cfg_addr];
    end
  end

  // Live registers and quarter lines. They change only on the apply edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_live[i] <= default_val(3'(i));
      end
      r_q14 <= 12'd310;
      r_q24 <= 12'd580;
      r_q34 <= 12'd850;
    end else if (w_load_live) begin
      for (int i = 0; i < 8; i++) begin
        r_live[i] <= r_shadow[i];
      end
      r_q14 <= w_q14;
      r_q24 <= w_q24;
      r_q34 <= w_q34;
    end else begin
      r_q14 <= r_q14;
      r_q24 <= r_q24;
      r_q34 <= r_q34;
    end
  end

  assign gen_reset_n = r_gen_reset_n;
  assign h_total     = r_live[0];
  assign h_sync      = r_live[1];
  assign h_start     = r_live[2];
  assign h_end       = r_live[3];
  assign v_total     = r_live[4];
  assign v_sync      = r_live[5];
  assign v_start     = r_live[6];
  assign v_end       = r_live[7];
  assign v_active_14 = r_q14;
  assign v_active_24 = r_q24;
  assign v_active_34 = r_q34;
  assign cfg_busy    = r_busy;
  assign cfg_done    = r_done;
  assign cfg_err     = r_err;
  assign cfg_timeout = r_timeout;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed testbench for vga_timing_ctrl (RST_CYCLES=16, TIMEOUT_W=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vga_timing_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_wdata;
  logic        cfg_commit;
  logic        vga_vs;
  logic        gen_reset_n;
  logic [11:0] h_total, h_sync, h_start, h_end;
  logic [11:0] v_total, v_sync, v_start, v_end;
  logic [11:0] v_active_14, v_active_24, v_active_34;
  logic        cfg_busy, cfg_done, cfg_err, cfg_timeout;

  int n_checks;
  int n_fail;
  int k;

  logic [11:0] exp1080 [0:10];
  logic [11:0] exp720  [0:10];

  vga_timing_ctrl #(.RST_CYCLES(16), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .vga_vs(vga_vs),
    .gen_reset_n(gen_reset_n),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .v_active_14(v_active_14), .v_active_24(v_active_24), .v_active_34(v_active_34),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_timeout(cfg_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] live(input int i);
    case (i)
      0: return h_total;
      1: return h_sync;
      2: return h_start;
      3: return h_end;
      4: return v_total;
      5: return v_sync;
      6: return v_start;
      7: return v_end;
      8: return v_active_14;
      9: return v_active_24;
      default: return v_active_34;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_live(input string tag, input bit use720);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("%s[%0d]", tag, i), 32'(live(i)), use720 ? 32'(exp720[i]) : 32'(exp1080[i]));
    end
  endtask

  // Count falling edges until gen_reset_n is high; k = 0 if it never rises.
  task automatic wait_high(input int start, output int kk);
    bit found;
    found = 1'b0;
    kk = start;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      kk++;
      if (gen_reset_n === 1'b1) found = 1'b1;
    end
    if (!found) kk = 0;
  endtask

  // Count falling edges until gen_reset_n is low; k = 0 if it never falls.
  task automatic wait_low(input int start, output int kk);
    bit found;
    found = 1'b0;
    kk = start;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      kk++;
      if (gen_reset_n === 1'b0) found = 1'b1;
    end
    if (!found) kk = 0;
  endtask

  initial begin
    exp1080[0] = 12'd2199; exp1080[1] = 12'd43;  exp1080[2] = 12'd189; exp1080[3]  = 12'd2109;
    exp1080[4] = 12'd1124; exp1080[5] = 12'd4;   exp1080[6] = 12'd40;  exp1080[7]  = 12'd1120;
    exp1080[8] = 12'd310;  exp1080[9] = 12'd580; exp1080[10] = 12'd850;
    exp720[0]  = 12'd1649; exp720[1]  = 12'd39;  exp720[2]  = 12'd259; exp720[3]   = 12'd1539;
    exp720[4]  = 12'd749;  exp720[5]  = 12'd4;   exp720[6]  = 12'd24;  exp720[7]   = 12'd744;
    exp720[8]  = 12'd204;  exp720[9]  = 12'd384; exp720[10] = 12'd564;

    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; cfg_wr = 1'b0; cfg_addr = 3'd0; cfg_wdata = 12'd0;
    cfg_commit = 1'b0; vga_vs = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gen_reset_n", 32'(gen_reset_n), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd1);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_timeout", 32'(cfg_timeout), 32'd0);
    chk_live("rst_live", 1'b0);

    // Reset release: 16-cycle HOLD, then done pulse
    reset_n = 1'b1;
    wait_high(0, k);
    chk("rst_hold_len", 32'(k), 32'd16);
    chk("rst_done_pulse", 32'(cfg_done), 32'd1);
    chk("rst_busy_clr", 32'(cfg_busy), 32'd0);
    chk_live("post_rst_live", 1'b0);
    @(negedge clk);
    chk("rst_done_one_cycle", 32'(cfg_done), 32'd0);

    // Write the 720p set; the live outputs must not move
    for (int i = 0; i < 8; i++) begin
      cfg_wr = 1'b1; cfg_addr = 3'(i); cfg_wdata = exp720[i];
      @(negedge clk);
    end
    cfg_wr = 1'b0;
    chk_live("live_after_wr", 1'b0);

    // Commit, then vsync after 100 cycles
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk("commit_busy", 32'(cfg_busy), 32'd1);
    chk("commit_no_err", 32'(cfg_err), 32'd0);
    repeat (100) @(negedge clk);
    chk("wait_gen_high", 32'(gen_reset_n), 32'd1);
    chk_live("wait_live", 1'b0);
    vga_vs = 1'b0;
    @(negedge clk);
    chk("vs_gen_low", 32'(gen_reset_n), 32'd0);
    chk_live("vs_live720", 1'b1);
    // Writes and commits while busy are ignored
    @(negedge clk);
    vga_vs = 1'b1;
    cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_wdata = 12'd100; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    chk("busy_commit_no_err", 32'(cfg_err), 32'd0);
    wait_high(2, k);
    chk("vs_hold_len", 32'(k), 32'd16);
    chk("vs_done", 32'(cfg_done), 32'd1);
    chk("vs_no_timeout", 32'(cfg_timeout), 32'd0);

    // Timeout path: vga_vs stays high
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk("to_busy", 32'(cfg_busy), 32'd1);
    wait_low(1, k);
    chk("to_latency", 32'(k), 32'd257);
    chk("to_sticky", 32'(cfg_timeout), 32'd1);
    chk("busy_wr_ignored", 32'(h_total), 32'd1649);
    wait_high(0, k);
    chk("to_hold_len", 32'(k), 32'd16);
    chk("to_done", 32'(cfg_done), 32'd1);
    chk("to_still_set", 32'(cfg_timeout), 32'd1);

    // A commit with a real vsync clears the timeout flag
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk("to_cleared_on_commit", 32'(cfg_timeout), 32'd0);
    repeat (5) @(negedge clk);
    vga_vs = 1'b0;
    @(negedge clk);
    vga_vs = 1'b1;
    chk("vs2_gen_low", 32'(gen_reset_n), 32'd0);
    chk("vs2_timeout", 32'(cfg_timeout), 32'd0);
    wait_high(0, k);
    chk("vs2_hold_len", 32'(k), 32'd16);

    // Invalid set: h_start > h_end
    cfg_wr = 1'b1; cfg_addr = 3'd2; cfg_wdata = 12'd2200;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk("err_pulse", 32'(cfg_err), 32'd1);
    chk("err_busy", 32'(cfg_busy), 32'd0);
    chk("err_live_h_start", 32'(h_start), 32'd259);
    @(negedge clk);
    chk("err_one_cycle", 32'(cfg_err), 32'd0);
    chk("err_gen_high", 32'(gen_reset_n), 32'd1);

    // Write + commit together: validation sees the old (invalid) value
    cfg_wr = 1'b1; cfg_addr = 3'd2; cfg_wdata = 12'd259; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    chk("wrcommit_err", 32'(cfg_err), 32'd1);
    chk("wrcommit_busy", 32'(cfg_busy), 32'd0);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk("recommit_ok", 32'(cfg_err), 32'd0);
    chk("recommit_busy", 32'(cfg_busy), 32'd1);

    // Reset during WAIT_VS
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_gen_low", 32'(gen_reset_n), 32'd0);
    chk("midrst_busy", 32'(cfg_busy), 32'd1);
    chk_live("midrst_live", 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_high(0, k);
    chk("midrst_hold_len", 32'(k), 32'd16);
    chk("midrst_done", 32'(cfg_done), 32'd1);
    chk("midrst_h_total", 32'(h_total), 32'd2199);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
